// File: rtl/pll_divbank_pkg.sv
// pll_divbank_pkg: shared types and constants for the PLL output divider bank
package pll_divbank_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, LOCKED} lock_st_t;
  localparam int MIN_DIV = 2;
  localparam int CH_W = 3;
endpackage

// File: rtl/pll_divbank_ch.sv
// pll_divbank_ch: one divider channel with clamped N/H, registered output and phase stepping
module pll_divbank_ch
  import pll_divbank_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             CLKI,
  input  logic             RSTN,
  input  logic             en,
  input  logic             gate,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] high,
  input  logic             step,
  input  logic             lag,
  output logic             clko,
  output logic             ack
);
  logic [DIV_W-1:0] cnt, nc_q, hc_q, nc, hc;
  logic run, hold, wrap, lead;
  always_comb begin
    nc = (div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div;
    hc = (high == '0) ? DIV_W'(1) : (high >= nc) ? nc - DIV_W'(1) : high;
    wrap = run && (cnt == nc_q - DIV_W'(1));
    lead = wrap && step && !lag;
  end
  // new N/H are only loaded at start or wrap so a period is never cut short
  always_ff @(posedge CLKI) begin
    if (!RSTN || !en) begin
      cnt  <= '0;
      nc_q <= DIV_W'(MIN_DIV);
      hc_q <= DIV_W'(1);
      run  <= 1'b0;
      hold <= 1'b0;
      clko <= 1'b0;
      ack  <= 1'b0;
    end else if (!run || wrap) begin
      run  <= 1'b1;
      nc_q <= nc;
      hc_q <= hc;
      cnt  <= lead ? DIV_W'(1) : '0;
      hold <= wrap && step && lag;
      ack  <= wrap && step;
      clko <= gate && (lead ? (hc > DIV_W'(1)) : 1'b1);
    end else if (hold) begin
      hold <= 1'b0;
      ack  <= 1'b0;
      clko <= gate;
    end else begin
      cnt  <= cnt + DIV_W'(1);
      ack  <= 1'b0;
      clko <= gate && ((cnt + DIV_W'(1)) < hc_q);
    end
  end
endmodule

// File: rtl/pll_divbank.sv
// pll_divbank: bank of aligned clock dividers with lock detect
// Dynamic phase adjust is built only when PLL_DIVBANK_DPA_EN is defined.
module pll_divbank
  import pll_divbank_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DIV_W        = 8,
  parameter int LOCK_CYC     = 16,
  parameter int WAKE_ON_LOCK = 1
) (
  input  logic                    CLKI,
  input  logic                    RSTN,
  input  logic                    EN,
  input  logic [NUM_CH*DIV_W-1:0] DIV,
  input  logic [NUM_CH*DIV_W-1:0] HIGH,
  input  logic                    PH_REQ,
  input  logic [CH_W-1:0]         PH_CH,
  input  logic                    PH_LAG,
  output logic                    PH_ACK,
  output logic                    PH_BUSY,
  output logic [NUM_CH-1:0]       CLKO,
  output logic                    LOCK
);
  localparam int LW = $clog2(LOCK_CYC + 1);
  lock_st_t st, st_n;
  logic [LW-1:0] lcnt;
  logic [NUM_CH*DIV_W-1:0] div_q;
  logic div_chg, lock_n, gate;
  logic [NUM_CH-1:0] ch_ack;
  logic step_on, step_lag;
  logic [CH_W-1:0] step_ch;
  always_ff @(posedge CLKI) begin
    if (!RSTN) st <= IDLE;
    else st <= st_n;
  end
  always_comb begin
    div_chg = DIV != div_q;
    st_n = !EN ? IDLE :
           (st == IDLE || div_chg) ? COUNT :
           (st == COUNT && lcnt == LW'(LOCK_CYC - 1)) ? LOCKED : st;
  end
  always_comb begin
    LOCK = st == LOCKED;
    lock_n = st_n == LOCKED;
    gate = (WAKE_ON_LOCK == 0) || lock_n;
  end
  always_ff @(posedge CLKI) begin
    if (!RSTN) begin
      lcnt  <= '0;
      div_q <= '0;
    end else begin
      div_q <= DIV;
      lcnt  <= (st == COUNT && st_n == COUNT && !div_chg) ? lcnt + LW'(1) : '0;
    end
  end
`ifdef PLL_DIVBANK_DPA_EN
  logic busy;
  logic [CH_W-1:0] ph_ch_q;
  logic ph_lag_q;
  // a step stays pending until its channel wraps; the ACK cycle blocks re-application
  always_ff @(posedge CLKI) begin
    if (!RSTN || !EN) begin
      busy     <= 1'b0;
      ph_ch_q  <= '0;
      ph_lag_q <= 1'b0;
    end else if (busy) begin
      busy <= !PH_ACK;
    end else if (PH_REQ && {1'b0, PH_CH} < (CH_W + 1)'(NUM_CH)) begin
      busy     <= 1'b1;
      ph_ch_q  <= PH_CH;
      ph_lag_q <= PH_LAG;
    end
  end
  assign PH_ACK   = |ch_ack;
  assign PH_BUSY  = busy;
  assign step_on  = busy && !PH_ACK;
  assign step_ch  = ph_ch_q;
  assign step_lag = ph_lag_q;
`else
  logic unused_ph;
  assign unused_ph = ^{PH_REQ, PH_CH, PH_LAG, ch_ack};
  assign PH_ACK   = 1'b0;
  assign PH_BUSY  = 1'b0;
  assign step_on  = 1'b0;
  assign step_ch  = '0;
  assign step_lag = 1'b0;
`endif
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pll_divbank_ch #(.DIV_W(DIV_W)) u_ch (
      .CLKI (CLKI),
      .RSTN (RSTN),
      .en   (EN),
      .gate (gate),
      .div  (DIV[c*DIV_W +: DIV_W]),
      .high (HIGH[c*DIV_W +: DIV_W]),
      .step (step_on && step_ch == CH_W'(c)),
      .lag  (step_lag),
      .clko (CLKO[c]),
      .ack  (ch_ack[c])
    );
  end
endmodule

// File: doc/pll_divbank.md
PLL_DIVBANK -- requirements
Module: pll_divbank

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4, meaning the number of output channels (1..8).
REQ-002 The module SHALL have parameter DIV_W, default 8, meaning the divider/duty field width per channel.
REQ-003 The module SHALL have parameter LOCK_CYC, default 16, meaning the stable CLKI cycles required before LOCK asserts.
REQ-004 The module SHALL have parameter WAKE_ON_LOCK, default 1, meaning CLKO is gated low until LOCK when 1.
REQ-005 The module SHALL have one clock and a synchronous, active-low reset, with the ports below.
- CLKI  in  1  fast (VCO-domain) clock.
- RSTN  in  1  synchronous active-low reset.
- EN  in  1  run enable.
- DIV  in  NUM_CH*DIV_W  per-channel divide ratio N.
- HIGH  in  NUM_CH*DIV_W  per-channel high-time H, in CLKI cycles.
- PH_REQ  in  1  phase-step request.
- PH_CH  in  3  target channel index.
- PH_LAG  in  1  step direction: 1 = lag, 0 = lead.
- PH_ACK  out  1  phase step applied, one-cycle pulse.
- PH_BUSY  out  1  phase step pending.
- CLKO  out  NUM_CH  registered divided outputs.
- LOCK  out  1  dividers stable.

Function
REQ-006 Each channel SHALL run a counter 0..Nc-1, with Nc = max(N,2); CLKO[c] SHALL be high while count < Hc, with Hc clamped to 1..Nc-1.
REQ-007 CLKO SHALL be registered: the period is exactly Nc CLKI cycles and the high time exactly Hc cycles.
REQ-008 On the cycle after EN rises, all counters SHALL start at 0 simultaneously, so all channels are rising-edge aligned.
REQ-009 While EN=0, counters SHALL hold at 0 and CLKO SHALL be 0.
REQ-010 A DIV or HIGH value that changes while running SHALL take effect at that channel's next wrap (count Nc-1 to 0), with no runt pulse.
REQ-011 The LOCK FSM SHALL have states IDLE, COUNT and LOCKED.
- IDLE to COUNT when EN=1.
- COUNT to LOCKED after LOCK_CYC consecutive cycles with EN=1 and DIV unchanged.
- Any state to IDLE when EN=0.
- COUNT or LOCKED to COUNT, with the counter cleared, when DIV changes.
REQ-012 LOCK SHALL be 1 only in LOCKED.
REQ-013 With WAKE_ON_LOCK=1, CLKO SHALL be 0 whenever LOCK=0 while the counters run; with WAKE_ON_LOCK=0, CLKO SHALL be ungated.
REQ-014 PH_REQ SHALL be accepted only when PH_BUSY=0 and PH_CH<NUM_CH; PH_BUSY SHALL assert on the cycle after acceptance.
REQ-015 Requests arriving while busy, or with PH_CH>=NUM_CH, SHALL be ignored with no ACK.
REQ-016 A pending step SHALL apply at the target channel's next wrap.
- Lag: hold count 0 for one extra cycle.
- Lead: skip count 0.
- Either way the channel shifts by exactly one CLKI cycle.
REQ-017 On the applying cycle PH_ACK SHALL pulse for 1 cycle and PH_BUSY SHALL clear on the following cycle.
REQ-018 Phase steps SHALL NOT affect LOCK.
REQ-019 If EN falls while a step is pending, the step SHALL be dropped with no ACK and PH_BUSY SHALL clear.

Reset
REQ-020 When RSTN=0 at a CLKI edge, all of the following SHALL be cleared:
- CLKO, LOCK, PH_ACK and PH_BUSY to 0.
- All counters to 0.
- The FSM to IDLE.
- Any pending phase step.
REQ-021 Reset asserted mid-operation SHALL take effect on the next edge, overriding all other inputs.

Configuration
REQ-022 Dynamic phase adjust SHALL be compiled in only when macro PLL_DIVBANK_DPA_EN is defined.
REQ-023 Without PLL_DIVBANK_DPA_EN:
- PH_REQ, PH_CH and PH_LAG SHALL be ignored.
- PH_ACK and PH_BUSY SHALL be tied to 0.
- Port list unchanged.

Structure
REQ-024 Package pll_divbank_pkg SHALL hold the LOCK FSM state typedef, the minimum divide constant (2) and the channel-index width (3).
REQ-025 One sub-module, pll_divbank_ch, SHALL implement a single channel:
- Counter, clamps and CLKO register.
- Phase-step application.
- Instantiated NUM_CH times.

Verification
REQ-026 Divide test: N=4, H=2, EN rises -> CLKO[0] period 4 cycles with 2 high; LOCK after 16 cycles; CLKO gated low before LOCK.
REQ-027 Clamp and alignment test: channel 1 with N=0, H=0 and channel 2 with N=5, H=9 -> channel 1 period 2, high 1; channel 2 period 5, high 4; rising edges aligned at start.
REQ-028 DIV change test: DIV[0] changes from 4 to 6 mid-run -> new period from next wrap, no runt pulse; LOCK drops for 16 cycles then reasserts.
REQ-029 Phase test (DPA_EN): lag on channel 0 then lead on channel 0 ->
- ACK 1 cycle each at wrap.
- Edge shifted +1 then back to 0.
- A second REQ while busy is ignored.
- A REQ with PH_CH=5 and NUM_CH=4 gives no ACK.
REQ-030 Reset test: RSTN=0 mid-pending-step -> all outputs 0 next edge; no ACK after release.
